// File: rtl/hearing_aid_pkg.sv
// Fixed-point constants, pipeline state encoding and saturation helpers
// shared by the hearing-aid processing blocks.
package hearing_aid_pkg;
    localparam int SAMPLE_W   = 24;
    localparam int COEFF_W    = 32;
    localparam int ACCUM_W    = 48;
    localparam int FRAC_SHIFT = COEFF_W - 2;
    // Operands are two bits wider than a coefficient so the 33-bit gain
    // difference and a negated -2.0 coefficient both fit.
    localparam int MUL_W      = COEFF_W + 2;
    localparam int PROD_W     = 2 * MUL_W;

    localparam logic signed [COEFF_W-1:0]  ONE_Q2_30  = 32'sh4000_0000;
    localparam logic signed [COEFF_W-1:0]  GAIN_MAX   = 32'sh7FFF_FFFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 24'sh7F_FFFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 24'sh80_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GATE,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_MAC4,
        S_GAIN,
        S_APPLY,
        S_MAKEUP,
        S_LIMIT
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] sat24(input logic signed [PROD_W-1:0] v);
        if (v > PROD_W'(SAMPLE_MAX)) return SAMPLE_MAX;
        if (v < PROD_W'(SAMPLE_MIN)) return SAMPLE_MIN;
        return v[SAMPLE_W-1:0];
    endfunction

    // One extra bit so the magnitude of the most negative sample is exact.
    function automatic logic [SAMPLE_W:0] abs24(input logic signed [SAMPLE_W-1:0] v);
        logic signed [SAMPLE_W:0] w;
        w = (SAMPLE_W+1)'(v);
        return w[SAMPLE_W] ? -w : w;
    endfunction
endpackage

// File: rtl/ha_biquad.sv
// Direct-form-I biquad: owns the x/y history and the accumulator, and
// presents multiplier operands for MAC0..MAC4 to the shared multiplier.
module ha_biquad
    import hearing_aid_pkg::*;
#(
    parameter int ACCUM_WIDTH = ACCUM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  state_t                     i_state,
    input  logic signed [SAMPLE_W-1:0] i_x,
    input  logic signed [COEFF_W-1:0]  i_b0,
    input  logic signed [COEFF_W-1:0]  i_b1,
    input  logic signed [COEFF_W-1:0]  i_b2,
    input  logic signed [COEFF_W-1:0]  i_a1,
    input  logic signed [COEFF_W-1:0]  i_a2,
    input  logic signed [PROD_W-1:0]   i_product,
    output logic signed [MUL_W-1:0]    o_mul_a,
    output logic signed [MUL_W-1:0]    o_mul_b,
    output logic signed [SAMPLE_W-1:0] o_y
);
    logic signed [SAMPLE_W-1:0]    r_x1, r_x2, r_y1, r_y2;
    logic signed [ACCUM_WIDTH-1:0] r_acc;
    logic signed [ACCUM_WIDTH-1:0] w_acc_sum;
    logic signed [SAMPLE_W-1:0]    w_y_new;

    // Feedback taps negate the coefficient so the floored product is of -a*y.
    always_comb begin
        o_mul_a = '0;
        o_mul_b = '0;
        case (i_state)
            S_MAC0: begin o_mul_a = MUL_W'(i_x);  o_mul_b = MUL_W'(i_b0);  end
            S_MAC1: begin o_mul_a = MUL_W'(r_x1); o_mul_b = MUL_W'(i_b1);  end
            S_MAC2: begin o_mul_a = MUL_W'(r_x2); o_mul_b = MUL_W'(i_b2);  end
            S_MAC3: begin o_mul_a = MUL_W'(r_y1); o_mul_b = -MUL_W'(i_a1); end
            S_MAC4: begin o_mul_a = MUL_W'(r_y2); o_mul_b = -MUL_W'(i_a2); end
            default: ;
        endcase
    end

    assign w_acc_sum = r_acc + ACCUM_WIDTH'(i_product >>> FRAC_SHIFT);
    assign w_y_new   = sat24(PROD_W'(w_acc_sum));
    assign o_y       = r_y1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_y1  <= '0;
            r_y2  <= '0;
        end else begin
            case (i_state)
                S_GATE: r_acc <= '0;
                S_MAC0, S_MAC1, S_MAC2, S_MAC3: r_acc <= w_acc_sum;
                S_MAC4: begin
                    r_acc <= w_acc_sum;
                    r_x2  <= r_x1;
                    r_x1  <= i_x;
                    r_y2  <= r_y1;
                    r_y1  <= w_y_new;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/hearing_aid_top.sv
// Hearing-aid pipeline: gate, biquad, smoothed compressor, makeup, limiter,
// all sharing one multiplier. Define HA_NOISE_GATE_EN to enable the noise gate.
module hearing_aid_top
    import hearing_aid_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int COEFF_WIDTH  = 32,
    parameter int ACCUM_WIDTH  = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in,
    input  logic                          audio_valid,
    output logic                          audio_ready,
    output logic signed [SAMPLE_WIDTH-1:0] audio_out,
    input  logic signed [COEFF_WIDTH-1:0] filter_coeffs_b0,
    input  logic signed [COEFF_WIDTH-1:0] filter_coeffs_b1,
    input  logic signed [COEFF_WIDTH-1:0] filter_coeffs_b2,
    input  logic signed [COEFF_WIDTH-1:0] filter_coeffs_a1,
    input  logic signed [COEFF_WIDTH-1:0] filter_coeffs_a2,
    input  logic        [SAMPLE_WIDTH-1:0] compressor_thresholds,
    input  logic signed [COEFF_WIDTH-1:0] compressor_ratios,
    input  logic signed [COEFF_WIDTH-1:0] compressor_attack_coeffs,
    input  logic signed [COEFF_WIDTH-1:0] compressor_release_coeffs,
    input  logic signed [COEFF_WIDTH-1:0] compressor_makeup_gains,
    input  logic        [SAMPLE_WIDTH-1:0] noise_gate_threshold,
    input  logic        [SAMPLE_WIDTH-1:0] limiter_threshold
);
    state_t                     r_state;
    logic signed [SAMPLE_W-1:0] r_x, r_s, r_out;
    logic signed [COEFF_W-1:0]  r_g;
    logic                       r_ready;

    logic signed [MUL_W-1:0]    w_mul_a, w_mul_b, w_bq_a, w_bq_b, w_gain_diff;
    logic signed [PROD_W-1:0]   w_product, w_scaled, w_g_sum;
    logic signed [SAMPLE_W-1:0] w_y, w_sat, w_limited;
    logic signed [COEFF_W-1:0]  w_gain_target, w_gain_coeff, w_g_next;

`ifndef HA_NOISE_GATE_EN
    logic w_unused_gate;
    assign w_unused_gate = ^noise_gate_threshold;
`endif

    assign audio_ready = r_ready;
    assign audio_out   = r_out;

    ha_biquad #(.ACCUM_WIDTH(ACCUM_WIDTH)) u_biquad (
        .clk       (clk),
        .rst       (rst),
        .i_state   (r_state),
        .i_x       (r_x),
        .i_b0      (filter_coeffs_b0),
        .i_b1      (filter_coeffs_b1),
        .i_b2      (filter_coeffs_b2),
        .i_a1      (filter_coeffs_a1),
        .i_a2      (filter_coeffs_a2),
        .i_product (w_product),
        .o_mul_a   (w_bq_a),
        .o_mul_b   (w_bq_b),
        .o_y       (w_y)
    );

    // The biquad drives zero operands outside MAC states, so it is the default.
    always_comb begin
        w_mul_a = w_bq_a;
        w_mul_b = w_bq_b;
        case (r_state)
            S_GAIN:   begin w_mul_a = w_gain_diff;  w_mul_b = MUL_W'(w_gain_coeff); end
            S_APPLY:  begin w_mul_a = MUL_W'(w_y);  w_mul_b = MUL_W'(r_g); end
            S_MAKEUP: begin w_mul_a = MUL_W'(r_s);  w_mul_b = MUL_W'(compressor_makeup_gains); end
            default: ;
        endcase
    end

    assign w_product = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
    assign w_scaled  = w_product >>> FRAC_SHIFT;
    assign w_sat     = sat24(w_scaled);

    assign w_gain_target = (abs24(w_y) > {1'b0, compressor_thresholds}) ? compressor_ratios : ONE_Q2_30;
    assign w_gain_coeff  = (w_gain_target < r_g) ? compressor_attack_coeffs : compressor_release_coeffs;
    assign w_gain_diff   = MUL_W'(w_gain_target) - MUL_W'(r_g);
    assign w_g_sum       = w_scaled + PROD_W'(r_g);

    always_comb begin
        w_g_next = w_g_sum[COEFF_W-1:0];
        if (w_g_sum[PROD_W-1])
            w_g_next = '0;
        else if (w_g_sum > PROD_W'(GAIN_MAX))
            w_g_next = GAIN_MAX;
    end

    always_comb begin
        w_limited = r_s;
        if ($signed({r_s[SAMPLE_W-1], r_s}) > $signed({1'b0, limiter_threshold}))
            w_limited = limiter_threshold;
        else if ($signed({r_s[SAMPLE_W-1], r_s}) < -$signed({1'b0, limiter_threshold}))
            w_limited = -limiter_threshold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_x     <= '0;
            r_s     <= '0;
            r_g     <= ONE_Q2_30;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (audio_valid) begin
                        r_x     <= audio_in;
                        r_ready <= 1'b0;
                        r_state <= S_GATE;
                    end
                end
                S_GATE: begin
`ifdef HA_NOISE_GATE_EN
                    if (abs24(r_x) < {1'b0, noise_gate_threshold})
                        r_x <= '0;
`endif
                    r_state <= S_MAC0;
                end
                S_MAC0: r_state <= S_MAC1;
                S_MAC1: r_state <= S_MAC2;
                S_MAC2: r_state <= S_MAC3;
                S_MAC3: r_state <= S_MAC4;
                S_MAC4: r_state <= S_GAIN;
                S_GAIN: begin
                    r_g     <= w_g_next;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    r_s     <= w_sat;
                    r_state <= S_MAKEUP;
                end
                S_MAKEUP: begin
                    r_s     <= w_sat;
                    r_state <= S_LIMIT;
                end
                S_LIMIT: begin
                    r_out   <= w_limited;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hearing_aid_top.sv
// Randomized bench for hearing_aid_top: a sample-level arithmetic model with
// cycle timing, checked every cycle, plus hand-computed directed expectations.
module tb_hearing_aid_top;
    localparam logic signed [31:0] ONE = 32'sh4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic audioValid = 1'b0;
    logic signed [23:0] audioIn = '0;
    logic audioReady;
    logic signed [23:0] audioOut;
    logic signed [31:0] b0, b1, b2, a1, a2, ratio, atkCoeff, relCoeff, makeup;
    logic [23:0] compThr, gateThr, limThr;

    int testsRun = 0;
    int testsFailed = 0;
    int failPrints = 0;

    longint mx1, mx2, my1, my2, mg;
    int pendCount;
    logic signed [23:0] pendOut, expOut;
    logic expReady;
    bit modelLive = 0;

    hearing_aid_top dut (
        .clk(clk), .rst(rst),
        .audio_in(audioIn), .audio_valid(audioValid),
        .audio_ready(audioReady), .audio_out(audioOut),
        .filter_coeffs_b0(b0), .filter_coeffs_b1(b1), .filter_coeffs_b2(b2),
        .filter_coeffs_a1(a1), .filter_coeffs_a2(a2),
        .compressor_thresholds(compThr), .compressor_ratios(ratio),
        .compressor_attack_coeffs(atkCoeff), .compressor_release_coeffs(relCoeff),
        .compressor_makeup_gains(makeup),
        .noise_gate_threshold(gateThr), .limiter_threshold(limThr)
    );

    always #5 clk = ~clk;

    function automatic longint satS(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic longint absL(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Whole-sample arithmetic straight from the processing rules.
    function automatic longint processSample(input longint xin);
        longint x, acc, y, gt, c, s, lim;
        x = xin;
`ifdef HA_NOISE_GATE_EN
        if (absL(x) < longint'(gateThr)) x = 0;
`endif
        acc = ((longint'(b0) * x) >>> 30) + ((longint'(b1) * mx1) >>> 30)
            + ((longint'(b2) * mx2) >>> 30) + ((-longint'(a1) * my1) >>> 30)
            + ((-longint'(a2) * my2) >>> 30);
        y = satS(acc);
        mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
        gt = (absL(y) > longint'(compThr)) ? longint'(ratio) : longint'(ONE);
        c = (gt < mg) ? longint'(atkCoeff) : longint'(relCoeff);
        mg = mg + ((c * (gt - mg)) >>> 30);
        if (mg < 0) mg = 0;
        if (mg > 64'sd2147483647) mg = 64'sd2147483647;
        s = satS((y * mg) >>> 30);
        s = satS((s * longint'(makeup)) >>> 30);
        lim = longint'(limThr);
        if (s > lim) s = lim;
        else if (s < -lim) s = -lim;
        return s;
    endfunction

    // Cycle timing: output and ready return on the 10th edge after acceptance.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; mg = longint'(ONE);
            pendCount = 0; expOut = '0; expReady = 1'b1; modelLive = 1;
        end else if (pendCount > 0) begin
            pendCount--;
            if (pendCount == 0) begin
                expOut = pendOut;
                expReady = 1'b1;
            end
        end else if (expReady && audioValid) begin
            pendOut = 24'(processSample(longint'(audioIn)));
            pendCount = 10;
            expReady = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (modelLive) begin
            testsRun++;
            if (audioReady !== expReady || audioOut !== expOut) begin
                testsFailed++;
                if (failPrints < 20)
                    $display("[TB] FAIL cycleCompare t=%0t ready=%b out=%h, expected ready=%b out=%h",
                             $time, audioReady, audioOut, expReady, expOut);
                failPrints++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] want);
        testsRun++;
        if (actual !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s got %h, expected %h", name, actual, want);
        end
    endtask

    task automatic applyStimulus(input logic signed [23:0] x, input bit holdValid);
        int waitCycles = 0;
        while (audioReady !== 1'b1 && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        if (audioReady !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL readyTimeout got ready=%b, expected 1", audioReady);
        end
        audioIn = x;
        audioValid = 1'b1;
        @(negedge clk);
        audioIn = 24'sh5A5A5A;
        if (!holdValid) audioValid = 1'b0;
        repeat (10) @(negedge clk);
        audioValid = 1'b0;
    endtask

    task automatic setPassthrough();
        b0 = ONE; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        ratio = ONE; atkCoeff = '0; relCoeff = '0; makeup = ONE;
        compThr = 24'h7FFFFF; gateThr = '0; limThr = 24'h7FFFFF;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomizeCoeffs();
        b0 = $urandom; b1 = $urandom; b2 = $urandom;
        a1 = $urandom; a2 = $urandom;
        ratio = $urandom_range(0, 32'h7FFF_FFFF);
        atkCoeff = $urandom_range(0, 32'h4000_0000);
        relCoeff = $urandom_range(0, 32'h4000_0000);
        makeup = $urandom;
        compThr = 24'($urandom);
        gateThr = 24'($urandom_range(0, 32'h0002_0000));
        limThr = 24'($urandom);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [23:0] gateWant;
        setPassthrough();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("resetOut", audioOut, 24'h000000);
        checkOutput("resetReady", 24'(audioReady), 24'h000001);

        applyStimulus(24'sh100000, 1'b0);
        checkOutput("passthrough", audioOut, 24'h100000);

        doReset();
        setPassthrough();
        b0 = '0; b1 = ONE;
        applyStimulus(24'sh010000, 1'b0);
        checkOutput("historyFirst", audioOut, 24'h000000);
        applyStimulus(24'sh020000, 1'b0);
        checkOutput("historySecond", audioOut, 24'h010000);

        doReset();
        setPassthrough();
        compThr = 24'h100000; ratio = 32'sh2000_0000; atkCoeff = ONE; relCoeff = '0;
        applyStimulus(24'sh400000, 1'b0);
        checkOutput("compressAttack", audioOut, 24'h200000);
        applyStimulus(24'sh010000, 1'b0);
        checkOutput("compressHold", audioOut, 24'h008000);

        doReset();
        setPassthrough();
        b0 = 32'sh6000_0000; limThr = 24'h400000;
        applyStimulus(24'sh600000, 1'b0);
        checkOutput("limitPos", audioOut, 24'h400000);
        applyStimulus(-24'sh600000, 1'b0);
        checkOutput("limitNeg", audioOut, 24'hC00000);

        doReset();
        setPassthrough();
        gateThr = 24'h001000;
`ifdef HA_NOISE_GATE_EN
        gateWant = 24'h000000;
`else
        gateWant = 24'h000800;
`endif
        applyStimulus(24'sh000800, 1'b1);
        checkOutput("gateBusyValid", audioOut, gateWant);

        doReset();
        setPassthrough();
        audioIn = 24'sh123456;
        audioValid = 1'b1;
        @(negedge clk);
        audioValid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("abortOut", audioOut, 24'h000000);
        applyStimulus(24'sh000123, 1'b0);
        checkOutput("afterAbort", audioOut, 24'h000123);

        doReset();
        randomizeCoeffs();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (audioReady && $urandom_range(0, 9) == 0) randomizeCoeffs();
            audioValid = ($urandom_range(0, 3) != 0);
            audioIn = 24'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        audioValid = 1'b0;
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
